// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, ALU/immediate/writeback
// encodings, control FSM states and small decode helpers.
package riscv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;
   localparam logic [3:0] ALU_SELB = 4'b1111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] WB_MEM = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXECUTE = 3'd3,
      MEM     = 3'd4,
      WB      = 3'd5,
      TRAP    = 3'd6
   } state_e;

   // Immediate format implied by the opcode; R-type and unknown opcodes use I.
   function automatic logic [2:0] imm_sel_of(input logic [6:0] opcode);
      logic [2:0] sel;
      sel = IMM_I;
      case (opcode)
         OPC_STORE:            sel = IMM_S;
         OPC_BRANCH:           sel = IMM_B;
         OPC_LUI, OPC_AUIPC:   sel = IMM_U;
         OPC_JAL:              sel = IMM_J;
         default:              sel = IMM_I;
      endcase
      return sel;
   endfunction

   // RV32I legality: opcode plus the funct3/funct7 combinations that exist.
   function automatic logic inst_legal(input logic [6:0] opcode,
                                       input logic [2:0] funct3,
                                       input logic [6:0] funct7);
      logic ok;
      ok = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: ok = 1'b1;
         OPC_JALR:   ok = (funct3 == 3'b000);
         OPC_BRANCH: ok = (funct3 != 3'b010) && (funct3 != 3'b011);
         OPC_LOAD:   ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         OPC_STORE:  ok = funct3 inside {3'b000, 3'b001, 3'b010};
         OPC_OP_IMM: begin
            if (funct3 == 3'b001)
               ok = (funct7 == 7'b0000000);
            else if (funct3 == 3'b101)
               ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            else
               ok = 1'b1;
         end
         OPC_OP: ok = (funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct3/funct7 to ALU operation decode.
module alu_decode
   import riscv_pkg::*;
#(
   parameter int unsigned WIDTH_ALUSEL_LENGTH = 4
) (
   input  logic [6:0]                     opcode,
   input  logic [2:0]                     funct3,
   input  logic                           funct7_5,
   output logic [WIDTH_ALUSEL_LENGTH-1:0] alu_sel
);

   logic [3:0] sel;

   // Address/target arithmetic uses ADD; only OP and OP-IMM decode funct3.
   always_comb begin
      sel = ALU_ADD;
      if (opcode == OPC_LUI) begin
         sel = ALU_SELB;
      end else if ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) begin
         case (funct3)
            3'b000:  sel = ((opcode == OPC_OP) && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
         endcase
      end
   end

   assign alu_sel = WIDTH_ALUSEL_LENGTH'(sel);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// datapath mux selects, write enables and memory request handshake.
module multicycle_control
   import riscv_pkg::*;
#(
   parameter int unsigned WIDTH_INST_LENGTH   = 32,
   parameter int unsigned WIDTH_ALUSEL_LENGTH = 4
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic [WIDTH_INST_LENGTH-1:0]   Inst,
   input  logic                           BrEq,
   input  logic                           BrLT,
   input  logic                           MemReady,
   output logic                           MemReq,
   output logic                           MemRW,
   output logic                           IRWrite,
   output logic                           PCWrite,
   output logic                           PCSel,
   output logic [2:0]                     ImmSel,
   output logic                           ASel,
   output logic                           BSel,
   output logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
   output logic                           BrUn,
   output logic                           RegWEn,
   output logic [1:0]                     WBSel,
   output logic                           IllegalInst
);

   state_e state;
   state_e state_next;
   logic   illegal_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       legal;
   logic       is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_op;
   logic       branch_taken;
   logic [WIDTH_ALUSEL_LENGTH-1:0] alu_op;
   logic       unused_inst_fields;

   assign opcode = Inst[6:0];
   assign funct3 = Inst[14:12];
   assign funct7 = Inst[31:25];
   assign unused_inst_fields = ^{Inst[24:15], Inst[11:7]};

   assign legal     = inst_legal(opcode, funct3, funct7);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_op     = (opcode == OPC_OP);

   alu_decode #(
      .WIDTH_ALUSEL_LENGTH (WIDTH_ALUSEL_LENGTH)
   ) u_alu_decode (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (funct7[5]),
      .alu_sel  (alu_op)
   );

   // Branch condition from the comparator flags, selected by funct3.
   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         3'b000:         branch_taken = BrEq;
         3'b001:         branch_taken = !BrEq;
         3'b100, 3'b110: branch_taken = BrLT;
         3'b101, 3'b111: branch_taken = !BrLT;
         default:        branch_taken = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Sticky illegal-instruction flag, set as DECODE rejects the opcode.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         illegal_q <= 1'b0;
      else if ((state == DECODE) && !legal)
         illegal_q <= 1'b1;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = FETCH;
         FETCH:   if (MemReady) state_next = DECODE;
         DECODE:  state_next = legal ? EXECUTE : TRAP;
         EXECUTE: state_next = (is_load || is_store) ? MEM : WB;
         MEM:     if (MemReady) state_next = WB;
         WB:      state_next = FETCH;
         TRAP:    state_next = TRAP;
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs from state and Inst; IRWrite is the only MemReady path.
   // Operand/ALU selects stay valid from EXECUTE through WB so the ALU
   // result feeding PC and writeback is stable when it is consumed.
   always_comb begin
      MemReq  = 1'b0;
      MemRW   = 1'b0;
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      PCSel   = 1'b0;
      ImmSel  = IMM_I;
      ASel    = 1'b0;
      BSel    = 1'b0;
      ALUSel  = '0;
      BrUn    = 1'b0;
      RegWEn  = 1'b0;
      WBSel   = WB_MEM;
      case (state)
         FETCH: begin
            MemReq  = 1'b1;
            IRWrite = MemReady;
         end
         DECODE: begin
            ImmSel = imm_sel_of(opcode);
         end
         EXECUTE, MEM, WB: begin
            ImmSel = imm_sel_of(opcode);
            ASel   = is_branch || is_auipc || is_jal;
            BSel   = !is_op;
            ALUSel = alu_op;
            BrUn   = is_branch && funct3[1];
            if (state == MEM) begin
               MemReq = 1'b1;
               MemRW  = is_store;
            end
            if (state == WB) begin
               PCWrite = 1'b1;
               RegWEn  = !(is_store || is_branch);
               if (is_load)
                  WBSel = WB_MEM;
               else if (is_jal || is_jalr)
                  WBSel = WB_PC4;
               else
                  WBSel = WB_ALU;
               PCSel = is_jal || is_jalr || (is_branch && branch_taken);
            end
         end
         default: ;
      endcase
   end

   assign IllegalInst = illegal_q;

endmodule
